// File: rtl/dbg_bus_master.sv
// dbg_bus_master: byte-stream command decoder acting as a second data-bus initiator.
// Frames: 0x57 addr[4] data[4] -> 0x4B; 0x52 addr[4] -> data[4]; anything else -> 0x3F.
module dbg_bus_master #(
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        bus_wr,
    output logic [31:0] bus_waddr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_rd,
    output logic [31:0] bus_raddr,
    input  logic [31:0] bus_rdata,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, READ, RDWAIT, RESP} state_t;
    state_t state, nxt;
    logic [1:0]  cnt, last;
    logic        is_wr, rcv, timeout, rx_ok, tx_done;
    logic [31:0] addr, resp, timer;
    logic [23:0] data;

    assign rcv       = state == ADDR || state == DATA;
    assign timeout   = rcv && timer == TIMEOUT;
    assign rx_ok     = rcv && rx_valid && !timeout;
    assign tx_done   = state == RESP && tx_valid && tx_ready;
    assign busy      = state != IDLE;
    assign bus_wr    = state == WRITE;
    assign bus_rd    = state == READ;
    assign bus_wstrb = {4{bus_wr}};

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (rx_valid) nxt = (rx_data == 8'h57 || rx_data == 8'h52) ? ADDR : RESP;
            ADDR:    nxt = timeout ? IDLE : (rx_ok && cnt == 2'd3) ? (is_wr ? DATA : READ) : ADDR;
            DATA:    nxt = timeout ? IDLE : (rx_ok && cnt == 2'd3) ? WRITE : DATA;
            WRITE:   nxt = RESP;
            READ:    nxt = RDWAIT;
            RDWAIT:  nxt = RESP;
            RESP:    if (tx_done && cnt == last) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            last      <= '0;
            is_wr     <= 1'b0;
            addr      <= '0;
            data      <= '0;
            resp      <= '0;
            timer     <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            bus_waddr <= '0;
            bus_wdata <= '0;
            bus_raddr <= '0;
        end else begin
            state <= nxt;
            timer <= (rcv && !rx_valid && !timeout) ? timer + 32'd1 : '0;
            if (state == IDLE)
                cnt <= '0;
            else if (rx_ok || tx_done)
                cnt <= cnt + 2'd1;
            if (state == IDLE && rx_valid) begin
                is_wr <= rx_data == 8'h57;
                resp  <= {8'h3F, 24'h0};
                last  <= '0;
            end
            if (rx_ok && state == ADDR) begin
                addr <= {addr[23:0], rx_data};
                if (cnt == 2'd3 && !is_wr) bus_raddr <= {addr[23:0], rx_data} & 32'hFFFF_FFFC;
            end
            if (rx_ok && state == DATA) begin
                data <= {data[15:0], rx_data};
                if (cnt == 2'd3) begin
                    bus_waddr <= addr & 32'hFFFF_FFFC;
                    bus_wdata <= {data, rx_data};
                end
            end
            if (state == WRITE) begin
                resp <= {8'h4B, 24'h0};
                last <= '0;
            end
            // Read data is held in the response shifter until the last byte leaves.
            if (state == RDWAIT) begin
                resp <= bus_rdata;
                last <= 2'd3;
            end
            if (state == RESP && !tx_valid) begin
                tx_valid <= 1'b1;
                tx_data  <= resp[31:24];
            end else if (tx_done) begin
                tx_valid <= cnt != last;
                if (cnt != last) begin
                    tx_data <= resp[23:16];
                    resp    <= {resp[23:0], 8'h0};
                end
            end
        end
    end
endmodule

// File: tb/tb_dbg_bus_master.sv
// tb_dbg_bus_master: table-driven frame vectors plus timeout, tx stall and mid-frame reset sequences.
module tb_dbg_bus_master;
    logic        clk, rstn, rx_valid, tx_valid, tx_ready, bus_wr, bus_rd, busy;
    logic [7:0]  rx_data, tx_data;
    logic [31:0] bus_waddr, bus_wdata, bus_raddr, bus_rdata, rd_val;
    logic [3:0]  bus_wstrb;

    dbg_bus_master #(.TIMEOUT(16)) dut (
        .clk(clk), .rstn(rstn), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .bus_wr(bus_wr), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rd(bus_rd), .bus_raddr(bus_raddr), .bus_rdata(bus_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data is only meaningful in the cycle after bus_rd; garbage otherwise.
    always @(posedge clk) bus_rdata <= bus_rd ? rd_val : 32'hBAD0_BAD0;

    int         errors = 0, checks = 0;
    int         wr_n = 0, rd_n = 0, strb_err = 0, both_err = 0, stall_err = 0;
    logic [7:0] txq[$];
    logic       pv = 1'b0, pr = 1'b0;
    logic [7:0] pd = '0;

    always @(negedge clk) begin
        if (bus_wr) wr_n++;
        if (bus_rd) rd_n++;
        if (bus_wstrb !== {4{bus_wr}}) strb_err++;
        if (bus_wr && bus_rd) both_err++;
        if (rstn && tx_valid && tx_ready) txq.push_back(tx_data);
        if (rstn && pv && !pr && (!tx_valid || tx_data !== pd)) stall_err++;
        pv = tx_valid;
        pr = tx_ready;
        pd = tx_data;
    end

    typedef struct packed {
        logic [3:0]  n;
        logic [71:0] b;
        logic [31:0] rdv;
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ntx;
        logic [31:0] tx;
    } vec_t;
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tx_valid"}, tx_valid, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_bus_wr"}, bus_wr, 0);
        chk({tag, "_bus_rd"}, bus_rd, 0);
        chk({tag, "_waddr"}, bus_waddr, 0);
        chk({tag, "_wdata"}, bus_wdata, 0);
        chk({tag, "_raddr"}, bus_raddr, 0);
        chk({tag, "_wstrb"}, bus_wstrb, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        chk(nm, busy, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int w0, r0, t0;
        w0 = wr_n; r0 = rd_n; t0 = txq.size();
        rd_val   = v.rdv;
        tx_ready = 1'b1;
        for (int i = 0; i < int'(v.n); i++) send_byte(v.b[71-8*i -: 8]);
        @(negedge clk);
        chk("wr_strobe_timing", bus_wr, v.kind == 2'd0);
        chk("rd_strobe_timing", bus_rd, v.kind == 2'd1);
        wait_idle("busy_clear");
        chk("wr_count", wr_n - w0, v.kind == 2'd0);
        chk("rd_count", rd_n - r0, v.kind == 2'd1);
        if (v.kind == 2'd0) begin
            chk("waddr", bus_waddr, v.addr);
            chk("wdata", bus_wdata, v.wdata);
        end
        if (v.kind == 2'd1) chk("raddr", bus_raddr, v.addr);
        chk("tx_count", txq.size() - t0, v.ntx);
        for (int i = 0; i < int'(v.ntx); i++)
            if (t0 + i < txq.size()) chk("tx_byte", txq[t0+i], v.tx[31-8*i -: 8]);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w0, r0, t0;
        vecs[0] = '{4'd9, 72'h57_0100_0006_DEAD_BEEF, 32'h0, 2'd0, 32'h0100_0004, 32'hDEAD_BEEF, 3'd1, 32'h4B00_0000};
        vecs[1] = '{4'd5, 72'h52_0100_0004_0000_0000, 32'h1234_5678, 2'd1, 32'h0100_0004, 32'h0, 3'd4, 32'h1234_5678};
        vecs[2] = '{4'd1, 72'hAA_0000_0000_0000_0000, 32'h0, 2'd2, 32'h0, 32'h0, 3'd1, 32'h3F00_0000};
        vecs[3] = '{4'd9, 72'h57_1234_5677_CAFE_F00D, 32'h0, 2'd0, 32'h1234_5674, 32'hCAFE_F00D, 3'd1, 32'h4B00_0000};
        vecs[4] = '{4'd5, 72'h52_FFFF_FFFF_0000_0000, 32'hA5A5_5A5A, 2'd1, 32'hFFFF_FFFC, 32'h0, 3'd4, 32'hA5A5_5A5A};
        vecs[5] = '{4'd1, 72'h00_0000_0000_0000_0000, 32'h0, 2'd2, 32'h0, 32'h0, 3'd1, 32'h3F00_0000};
        vecs[6] = '{4'd1, 72'h58_0000_0000_0000_0000, 32'h0, 2'd2, 32'h0, 32'h0, 3'd1, 32'h3F00_0000};
        rstn = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b1; rd_val = '0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset");
        rstn = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Inter-byte silence abandons the frame with no access and no response.
        w0 = wr_n; t0 = txq.size();
        send_byte(8'h57);
        send_byte(8'h01);
        repeat (14) @(negedge clk);
        chk("timeout_still_busy", busy, 1);
        repeat (6) @(negedge clk);
        chk("timeout_idle", busy, 0);
        chk("timeout_no_wr", wr_n - w0, 0);
        chk("timeout_no_tx", txq.size() - t0, 0);
        @(posedge clk);
        #1 run_vec('{4'd5, 72'h52_0000_0000_0000_0000, 32'h00C0_FFEE, 2'd1, 32'h0, 32'h0, 3'd4, 32'h00C0_FFEE});

        // Stalled transmitter: data must hold; rx bytes during the response are dropped.
        r0 = rd_n; t0 = txq.size();
        rd_val   = 32'h0F1E_2D3C;
        tx_ready = 1'b0;
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        @(negedge clk);
        chk("stall_rd_strobe", bus_rd, 1);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 50 && !tx_valid; i++) @(negedge clk);
            chk("stall_tx_valid", tx_valid, 1);
            if (k == 0) send_byte(8'h57);
            if (k == 2) send_byte(8'h52);
            repeat (10) @(negedge clk);
            @(posedge clk);
            #1 tx_ready = 1'b1;
            @(posedge clk);
            #1 tx_ready = 1'b0;
        end
        wait_idle("stall_busy_clear");
        repeat (5) @(negedge clk);
        chk("stall_rx_dropped", busy, 0);
        chk("stall_raddr", bus_raddr, 32'h0000_0100);
        chk("stall_rd_count", rd_n - r0, 1);
        chk("stall_tx_count", txq.size() - t0, 4);
        for (int i = 0; i < 4; i++)
            if (t0 + i < txq.size()) chk("stall_tx_byte", txq[t0+i], 8'h0F + 8'h0F * i);
        chk("stall_data_stable", stall_err, 0);
        tx_ready = 1'b1;

        // Reset after the third data byte of a write frame.
        @(posedge clk);
        #1 w0 = wr_n; t0 = txq.size();
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        #2 rstn = 1'b0;
        #1 chk_zero("midreset");
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        repeat (20) @(negedge clk);
        chk("midreset_no_wr", wr_n - w0, 0);
        chk("midreset_no_tx", txq.size() - t0, 0);
        chk("midreset_idle", busy, 0);
        @(posedge clk);
        #1 run_vec('{4'd9, 72'h57_8000_0003_0102_0304, 32'h0, 2'd0, 32'h8000_0000, 32'h0102_0304, 3'd1, 32'h4B00_0000});

        chk("wstrb_consistent", strb_err, 0);
        chk("no_wr_rd_overlap", both_err, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dbg_bus_master.md
DBG_BUS_MASTER -- requirements
Module: dbg_bus_master

Interface
REQ-001 Parameter TIMEOUT, default 100000: idle clk cycles allowed between bytes inside a frame before abort.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 rx_valid  input  1  one-cycle strobe: rx_data holds a received UART byte.
REQ-005 rx_data  input  8  received byte.
REQ-006 tx_valid  output  1  response byte available.
REQ-007 tx_data  output  8  response byte.
REQ-008 tx_ready  input  1  UART transmitter accepts the byte.
REQ-009 bus_wr  output  1  data-bus write strobe, one cycle.
REQ-010 bus_waddr  output  32  write address, word aligned.
REQ-011 bus_wdata  output  32  write data.
REQ-012 bus_wstrb  output  4  byte strobes; always 4'b1111 when bus_wr=1, else 4'b0000.
REQ-013 bus_rd  output  1  data-bus read strobe, one cycle.
REQ-014 bus_raddr  output  32  read address, word aligned.
REQ-015 bus_rdata  input  32  read data, valid the cycle after bus_rd.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The block SHALL act as a second data-bus initiator driven by a byte-stream command protocol; all multi-byte fields are MSB first.
REQ-018 Write frame: 0x57, 4 address bytes, 4 data bytes; response 0x4B.
REQ-019 Read frame: 0x52, 4 address bytes; response 4 data bytes, MSB first.
REQ-020 Any other command byte in IDLE SHALL produce response 0x3F and return to IDLE.
REQ-021 States: IDLE, ADDR (byte count 0-3), DATA (0-3), WRITE, READ, RDWAIT, RESP (byte count 0-3).
REQ-022 Transitions: IDLE->ADDR on 0x57/0x52; IDLE->RESP on unknown; ADDR->DATA (write) or READ (read) on 4th address byte; DATA->WRITE on 4th data byte; WRITE->RESP; READ->RDWAIT->RESP; RESP->IDLE when last response byte is accepted.
REQ-023 Address bits [1:0] SHALL be forced to 0 on bus_waddr/bus_raddr.
REQ-024 If the last frame byte is accepted at edge N, bus_wr or bus_rd SHALL be high for exactly the cycle following edge N.
REQ-025 Read data SHALL be captured from bus_rdata on the edge ending the RDWAIT cycle (one cycle after bus_rd) and held internally until the response completes.
REQ-026 bus_wr and bus_rd SHALL never be high simultaneously; bus outputs other than strobes hold last value when idle.
REQ-027 tx_valid SHALL rise the cycle after RESP is entered; tx_data SHALL stay stable while tx_valid=1 and tx_ready=0.
REQ-028 A byte is transferred on an edge with tx_valid=1 and tx_ready=1; the next byte (if any) SHALL be presented the following cycle; tx_valid low between bytes is permitted for one cycle only.
REQ-029 rx_valid strobes in WRITE, READ, RDWAIT or RESP SHALL be ignored (byte dropped).
REQ-030 In ADDR or DATA a 32-bit counter SHALL reset on each rx_valid and increment otherwise; at count == TIMEOUT the frame SHALL be abandoned to IDLE with no bus access and no response.
REQ-031 Timeout counter SHALL be held at 0 in IDLE and in all non-receiving states.

Reset
REQ-032 While rstn=0: state IDLE, all counters 0, tx_valid=0, tx_data=0, bus_wr=0, bus_rd=0, bus_waddr=0, bus_raddr=0, bus_wdata=0, bus_wstrb=0, busy=0.
REQ-033 Reset asserted mid-frame or mid-response SHALL abort immediately with no further bus strobe or tx byte after release; first frame after release is decoded from its command byte.

Verification
REQ-034 Write: 57 01 00 00 06 DE AD BE EF, tx_ready=1 -> one bus_wr cycle, waddr=0x01000004, wdata=0xDEADBEEF, wstrb=F; tx 0x4B.
REQ-035 Read: 52 01 00 00 04, bus_rdata=0x12345678 the cycle after bus_rd -> raddr=0x01000004, tx 12 34 56 78 in order.
REQ-036 Unknown byte 0xAA -> tx 0x3F, no bus strobe, busy returns to 0.
REQ-037 TIMEOUT=16: send 57 01, then silence 20 cycles -> no bus_wr, no tx, IDLE; next 52 00 00 00 00 works.
REQ-038 Read with tx_ready low for 10 cycles per byte -> tx_data stable while stalled; rx bytes sent during RESP produce nothing.
REQ-039 rstn pulsed low after 3rd data byte of write frame -> no bus_wr, all outputs 0; subsequent full write frame completes normally.
